// File: rtl/apb_cmd_master_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_cmd_master_pkg                                            |
// | Purpose  : Shared types and default constants for the APB command        |
// |            master: FSM state encoding and default bus geometry.          |
// | Contents : ST_W, ADDR_W_DEF, DATA_W_DEF, TIMEOUT_CYC_DEF, state_e        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package apb_cmd_master_pkg;

  localparam int ST_W            = 2;
  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_cmd_master_if                                             |
// | Purpose  : Bundles the command port, response port and APB3 requester    |
// |            signals of apb_cmd_master.                                    |
// | Modports : master - the apb_cmd_master side                              |
// |            slave  - the environment side (command source, response       |
// |                     sink and APB completer)                              |
// | Signals  : cmd_valid/ready/write/addr/wdata, rsp_valid/ready/rdata/err/   |
// |            timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, |
// |            PSLVERR                                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface apb_cmd_master_if
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-3:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB3 bus
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-3:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface
`default_nettype wire

// File: rtl/apb_cmd_master_tocnt.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_cmd_master_tocnt                                          |
// | Purpose  : ACCESS-phase wait counter for the APB command master.         |
// |            Counts wait cycles and flags the cycle on which the count     |
// |            reaches TIMEOUT_CYC.                                          |
// | Ports    : clk_i      - clock                                            |
// |            rst_ni     - asynchronous active-low reset                    |
// |            clr_i      - restart the count                                |
// |            inc_i      - one more wait cycle this clock                   |
// |            expired_o  - this wait cycle is the TIMEOUT_CYC-th one        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apb_cmd_master_tocnt
  import apb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic clr_i,
  input  wire logic inc_i,
  output logic      expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at TIMEOUT_CYC so a stalled transfer never wraps around.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the wait cycle whose increment brings the count to TIMEOUT_CYC,
  // so the abort lands on the same edge rather than one cycle later.
  assign expired_o = inc_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_cmd_master                                                |
// | Purpose  : APB3 requester. Accepts one command at a time on a            |
// |            valid/ready port, runs it as an APB SETUP/ACCESS transfer     |
// |            and returns read data / error on a valid/ready response port. |
// | Ports    : clk_i   - clock, rising edge                                  |
// |            rst_ni  - asynchronous active-low reset                       |
// |            bus_if  - apb_cmd_master_if.master (command, response, APB)   |
// | Options  : APB_CMD_MASTER_TIMEOUT_EN - abort ACCESS after TIMEOUT_CYC    |
// |            wait cycles and report rsp_err=1, rsp_timeout=1. Without it   |
// |            ACCESS waits for PREADY indefinitely and rsp_timeout is 0.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  apb_cmd_master_if.master  bus_if
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYC must be at least 1");
  end

  state_e            state_q,     state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-3:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              to_expired;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              to_clr;
  logic              to_inc;

  // Restart on SETUP; count only stalled ACCESS cycles.
  assign to_clr = (state_q == SETUP);
  assign to_inc = (state_q == ACCESS) && !bus_if.PREADY;

  apb_cmd_master_tocnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tocnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (to_clr),
    .inc_i     (to_inc),
    .expired_o (to_expired)
  );

  assign bus_if.rsp_timeout = rsp_timeout_q;
`else
  assign to_expired         = 1'b0;
  assign bus_if.rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus_if.cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          paddr_d     = bus_if.cmd_addr;
          pwrite_d    = bus_if.cmd_write;
          pwdata_d    = bus_if.cmd_wdata;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus_if.PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          // Writes return zero so stale read data never leaks out.
          rsp_rdata_d = pwrite_q ? '0 : bus_if.PRDATA;
          rsp_err_d   = bus_if.PSLVERR;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else if (to_expired) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b1;
`endif
        end
      end

      RESP: begin
        if (bus_if.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus_if.cmd_ready = cmd_ready_q;
  assign bus_if.PSEL      = psel_q;
  assign bus_if.PENABLE   = penable_q;
  assign bus_if.PWRITE    = pwrite_q;
  assign bus_if.PADDR     = paddr_q;
  assign bus_if.PWDATA    = pwdata_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb_cmd_master                                             |
// | Purpose  : Self-checking bench for apb_cmd_master with a stub APB        |
// |            completer (memory-backed, programmable wait states / error).  |
// | Options  : APB_CMD_MASTER_TIMEOUT_EN enables the timeout sequence.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          wt;
    bit          er;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus.master)
  );

  always #5 clk = ~clk;

  // Stub completer state and the bench's own model of its memory.
  int          stub_wait = 0;
  bit          stub_err  = 1'b0;
  int          acc_cnt   = 0;
  logic [31:0] stub_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  // Bus monitor state.
  int          setup_cnt  = 0;
  int          en_cnt     = 0;
  int          stable_bad = 0;
  int          gap_bad    = 0;
  bit          psel_prev  = 1'b0;
  logic [9:0]  snap_addr  = '0;
  logic        snap_wr    = 1'b0;
  logic [31:0] snap_wd    = '0;

  function automatic logic [31:0] dflt(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Stub completer: PREADY after stub_wait stalled ACCESS cycles; garbage on
  // PRDATA/PSLVERR whenever PREADY is low.
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (acc_cnt >= stub_wait) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = stub_err;
        if (bus.PWRITE) begin
          bus.PRDATA = $urandom;
          if (!stub_err) stub_mem[bus.PADDR] = bus.PWDATA;
        end else begin
          bus.PRDATA = stub_mem[bus.PADDR];
        end
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom % 2);
      end
      acc_cnt++;
    end else begin
      acc_cnt     = 0;
      bus.PREADY  = 1'($urandom % 2);
      bus.PRDATA  = $urandom;
      bus.PSLVERR = 1'($urandom % 2);
    end
  end

  // Monitor: phase counts, address/data stability, idle gap between transfers.
  always @(negedge clk) begin
    if (bus.PSEL && !bus.PENABLE) begin
      setup_cnt++;
      if (psel_prev) gap_bad++;
      snap_addr = bus.PADDR;
      snap_wr   = bus.PWRITE;
      snap_wd   = bus.PWDATA;
    end
    if (bus.PSEL && bus.PENABLE) begin
      en_cnt++;
      if (bus.PADDR !== snap_addr || bus.PWRITE !== snap_wr || bus.PWDATA !== snap_wd)
        stable_bad++;
    end
    psel_prev = bus.PSEL;
  end

  task automatic garble();
    bus.cmd_valid = 1'($urandom % 2);
    bus.cmd_write = 1'($urandom % 2);
    bus.cmd_addr  = 10'($urandom);
    bus.cmd_wdata = $urandom;
  endtask

  task automatic run_cmd(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                         input int wt, input bit er, input int hold,
                         input logic [31:0] exp_rdata, input bit exp_err, input bit exp_to,
                         input int exp_lat, input int exp_en);
    int n;
    int lat;
    int hold_bad;
    logic [31:0] r_rd;
    logic        r_err;
    logic        r_to;
    @(negedge clk);
    stub_wait     = wt;
    stub_err      = er;
    setup_cnt     = 0;
    en_cnt        = 0;
    stable_bad    = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      garble();
      bus.rsp_ready = 1'($urandom % 2);
      @(negedge clk);
      lat++;
    end
    bus.rsp_ready = 1'b0;
    if (!bus.rsp_valid) begin
      check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    check("latency",      32'(lat), 32'(exp_lat));
    check("rsp_rdata",    bus.rsp_rdata, exp_rdata);
    check("rsp_err",      32'(bus.rsp_err), 32'(exp_err));
    check("rsp_timeout",  32'(bus.rsp_timeout), 32'(exp_to));
    check("setup_cycles", 32'(setup_cnt), 32'd1);
    check("access_cycles", 32'(en_cnt), 32'(exp_en));
    check("apb_stable",   32'(stable_bad), 32'd0);
    check("paddr",        32'(snap_addr), 32'(addr));
    check("pwrite",       32'(snap_wr), 32'(wr));
    check("pwdata",       snap_wd, wdata);
    check("psel_in_resp", 32'(bus.PSEL), 32'd0);
    r_rd     = bus.rsp_rdata;
    r_err    = bus.rsp_err;
    r_to     = bus.rsp_timeout;
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      garble();
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== r_rd || bus.rsp_err !== r_err ||
          bus.rsp_timeout !== r_to || bus.cmd_ready || bus.PSEL)
        hold_bad++;
    end
    if (hold > 0) check("rsp_hold", 32'(hold_bad), 32'd0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    check("cmd_ready_after_hs", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [0:8];
    bit          r_wr;
    bit          r_er;
    logic [9:0]  r_a;
    logic [31:0] r_wd;
    int          r_wt;
    int          r_hold;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      stub_mem[i] = dflt(i);
      ref_mem[i]  = dflt(i);
    end

    //          wr    addr     wdata         wt er   hold exp_rdata      exp_err
    vecs[0] = '{1'b1, 10'h002, 32'h0000_000A, 0, 1'b0, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 10'h002, 32'h0000_0000, 0, 1'b0, 0, 32'h0000_000A, 1'b0};
    vecs[2] = '{1'b1, 10'h010, 32'hDEAD_BEEF, 1, 1'b0, 0, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 10'h010, 32'h0000_0000, 3, 1'b0, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b1, 10'h011, 32'h1234_5678, 0, 1'b1, 0, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b0, 10'h011, 32'h0000_0000, 0, 1'b0, 0, 32'hC0DE_0011, 1'b0};
    vecs[6] = '{1'b0, 10'h002, 32'h0000_0000, 0, 1'b0, 5, 32'h0000_000A, 1'b0};
    vecs[7] = '{1'b0, 10'h010, 32'h0000_0000, 2, 1'b1, 2, 32'hDEAD_BEEF, 1'b1};
    vecs[8] = '{1'b1, 10'h3FF, 32'hFFFF_FFFF, 0, 1'b0, 1, 32'h0000_0000, 1'b0};

    // Reset values, sampled while reset is held.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",   32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid",   32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err",     32'(bus.rsp_err), 32'd0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("rst_psel",        32'(bus.PSEL), 32'd0);
    check("rst_penable",     32'(bus.PENABLE), 32'd0);
    check("rst_pwrite",      32'(bus.PWRITE), 32'd0);
    check("rst_paddr",       32'(bus.PADDR), 32'd0);
    check("rst_pwdata",      bus.PWDATA, 32'd0);
    check("rst_rsp_rdata",   bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wt, vecs[i].er, vecs[i].hold,
              vecs[i].exp_rdata, vecs[i].exp_err, 1'b0, 2 + vecs[i].wt, vecs[i].wt + 1);
      if (vecs[i].wr && !vecs[i].er) ref_mem[vecs[i].addr] = vecs[i].wdata;
    end
    run_cmd(1'b0, 10'h3FF, 32'h0, 0, 1'b0, 0, ref_mem[10'h3FF], 1'b0, 1'b0, 2, 1);

    // Reset asserted in the middle of an ACCESS phase.
    @(negedge clk);
    stub_wait     = 20;
    stub_err      = 1'b0;
    check("pre_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 10'h002;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_psel",      32'(bus.PSEL), 32'd0);
    check("async_rst_penable",   32'(bus.PENABLE), 32'd0);
    check("async_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1'b0, 10'h002, 32'h0, 1, 1'b0, 0, ref_mem[10'h002], 1'b0, 1'b0, 3, 2);

    // Randomised traffic against the memory model.
    for (int k = 0; k < 40; k++) begin
      r_wr   = 1'($urandom % 2);
      r_er   = ($urandom % 6) == 0;
      r_a    = (($urandom % 8) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      r_wd   = $urandom;
      r_wt   = $urandom_range(0, 4);
      r_hold = $urandom_range(0, 3);
      run_cmd(r_wr, r_a, r_wd, r_wt, r_er, r_hold,
              r_wr ? 32'h0 : ref_mem[r_a], r_er, 1'b0, 2 + r_wt, r_wt + 1);
      if (r_wr && !r_er) ref_mem[r_a] = r_wd;
    end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // Completer never answers: abort after TIMEOUT_CYC stalled ACCESS cycles.
    run_cmd(1'b0, 10'h020, 32'h0, 1000, 1'b0, 2, 32'h0, 1'b1, 1'b1,
            TIMEOUT_CYC + 1, TIMEOUT_CYC);
    run_cmd(1'b0, 10'h020, 32'h0, 0, 1'b0, 0, ref_mem[10'h020], 1'b0, 1'b0, 2, 1);
`endif

    check("psel_idle_gap", 32'(gap_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
